// File: rtl/ysyx_22040237_mdu_seq.sv
// rtl/ysyx_22040237_mdu_seq.sv - iterative RV64M multiply/divide sequencer
module ysyx_22040237_mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_idx_i,
  input  logic            flush_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_o,
  output logic [4:0]      rd_idx_o,
  output logic            busy_o
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // multiplier+product low half / dividend+quotient
  logic [XLEN-1:0] b_q, b_d;       // multiplicand / divisor magnitude
  logic [XLEN-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;

  function automatic logic [XLEN-1:0] sext_w(input logic [HW-1:0] x);
    return {{HW{x[HW-1]}}, x};
  endfunction

  logic is_mul, is_div, is_w, is_rem, is_high, sign_a, sign_b, illegal;

  // Op decode: class, word size and which operands are signed
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_w    = 1'b0;
    is_rem  = 1'b0;
    is_high = 1'b0;
    sign_a  = 1'b0;
    sign_b  = 1'b0;
    case (op_q)
      4'd0:  is_mul = 1'b1;
      4'd1:  begin is_mul = 1'b1; is_high = 1'b1; sign_a = 1'b1; sign_b = 1'b1; end
      4'd2:  begin is_mul = 1'b1; is_high = 1'b1; sign_a = 1'b1; end
      4'd3:  begin is_mul = 1'b1; is_high = 1'b1; end
      4'd4:  begin is_div = 1'b1; sign_a = 1'b1; sign_b = 1'b1; end
      4'd5:  is_div = 1'b1;
      4'd6:  begin is_div = 1'b1; is_rem = 1'b1; sign_a = 1'b1; sign_b = 1'b1; end
      4'd7:  begin is_div = 1'b1; is_rem = 1'b1; end
      4'd8:  begin is_mul = 1'b1; is_w = 1'b1; end
      4'd9:  begin is_div = 1'b1; is_w = 1'b1; sign_a = 1'b1; sign_b = 1'b1; end
      4'd10: begin is_div = 1'b1; is_w = 1'b1; end
      4'd11: begin is_div = 1'b1; is_w = 1'b1; is_rem = 1'b1; sign_a = 1'b1; sign_b = 1'b1; end
      4'd12: begin is_div = 1'b1; is_w = 1'b1; is_rem = 1'b1; end
      default: ;
    endcase
    illegal = ~is_mul & ~is_div;
  end

  logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, min_neg, fast_res;
  logic            neg_a, neg_b, div_zero, div_ovf;

  // Operand preparation: word extension, magnitudes and the fast-path results
  always_comb begin
    ext_a = lo_q;
    ext_b = b_q;
    if (is_w) begin
      ext_a = sign_a ? sext_w(lo_q[HW-1:0]) : {{HW{1'b0}}, lo_q[HW-1:0]};
      ext_b = sign_b ? sext_w(b_q[HW-1:0])  : {{HW{1'b0}}, b_q[HW-1:0]};
    end
    neg_a    = sign_a & ext_a[XLEN-1];
    neg_b    = sign_b & ext_b[XLEN-1];
    mag_a    = neg_a ? -ext_a : ext_a;
    mag_b    = neg_b ? -ext_b : ext_b;
    min_neg  = is_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div & (ext_b == '0);
    div_ovf  = is_div & sign_a & (ext_a == min_neg) & (ext_b == '1);
    fast_res = '0;
    if (div_zero) begin
      fast_res = is_rem ? (is_w ? sext_w(ext_a[HW-1:0]) : ext_a) : '1;
    end else if (div_ovf) begin
      fast_res = is_rem ? '0 : ext_a;
    end
  end

  logic [XLEN:0]   mul_sum, div_trial;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  // One iteration: shift-add for multiply, trial subtract for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    div_trial = {acc_q, lo_q[XLEN-1]};
    div_ge    = (div_trial >= {1'b0, b_q});
    div_diff  = div_trial[XLEN-1:0] - b_q;
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   dv_mag, dv_fix, fix_res;

  // Final sign correction and result selection
  always_comb begin
    prod_fix = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    dv_mag   = is_rem ? acc_q : lo_q;
    dv_fix   = neg_q ? -dv_mag : dv_mag;
    if (is_mul) begin
      if (is_w) begin
        // after HW steps the low word of the product sits in the top half of lo
        fix_res = sext_w(lo_q[XLEN-1:HW]);
      end else if (is_high) begin
        fix_res = prod_fix[2*XLEN-1:XLEN];
      end else begin
        fix_res = prod_fix[XLEN-1:0];
      end
    end else begin
      fix_res = is_w ? sext_w(dv_fix[HW-1:0]) : dv_fix;
    end
  end

  // Next-state and datapath register updates; flush overrides everything
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = op_i;
          rd_d    = rd_idx_i;
          lo_d    = op1_i;
          b_d     = op2_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_d = is_rem ? neg_a : (neg_a ^ neg_b);
        if (illegal | div_zero | div_ovf) begin
          res_d   = fast_res;
          state_d = S_DONE;
        end else begin
          acc_d   = '0;
          // word divides feed the dividend from the top so only HW steps are needed
          lo_d    = (is_w & is_div) ? {mag_a[HW-1:0], {HW{1'b0}}} : mag_a;
          b_d     = mag_b;
          cnt_d   = is_w ? CW'(HW) : CW'(XLEN);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_mul) begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
          acc_d = div_ge ? div_diff : div_trial[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], div_ge};
        end
        if (cnt_q == CW'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        res_d   = fix_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d = S_IDLE;
      res_d   = '0;
      rd_d    = '0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE) & ~flush_i;
  assign res_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign res_o       = res_q;
  assign rd_idx_o    = rd_q;

endmodule
